// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - display/writer arbiter for the single-port board RAM
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   vblank                           high outside active video lines
//   disp_req/disp_addr               display read request
//   disp_gnt/disp_rvalid/disp_rdata  display grant and read return
//   wr_req/wr_we/wr_addr/wr_wdata    writer request (read or write)
//   wr_gnt/wr_rvalid/wr_rdata        writer grant and read return
//   mem_en/mem_we/mem_addr/mem_wdata RAM command
//   mem_rdata                        RAM read data, one cycle after a read
module vram_arbiter #(
   parameter int AW         = 4,
   parameter int DW         = 4,
   parameter int STARVE_MAX = 200,
   parameter int TEAR_FREE  = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          vblank,
   input  logic          disp_req,
   input  logic [AW-1:0] disp_addr,
   output logic          disp_gnt,
   output logic          disp_rvalid,
   output logic [DW-1:0] disp_rdata,
   input  logic          wr_req,
   input  logic          wr_we,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_wdata,
   output logic          wr_gnt,
   output logic          wr_rvalid,
   output logic [DW-1:0] wr_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      TAG_NONE = 2'd0,
      TAG_DISP = 2'd1,
      TAG_WRD  = 2'd2
   } tag_e;

   localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

   logic          wr_ok;
   logic [7:0]    starve_cnt_q, starve_cnt_d;
   logic          force_q, force_d;
   tag_e          tag_q, tag_d;
   logic [DW-1:0] disp_rdata_q, disp_rdata_d;
   logic [DW-1:0] wr_rdata_q, wr_rdata_d;

   always_comb begin
      wr_ok = wr_req & (vblank | (TEAR_FREE == 0));

      // Priority: forced writer, then display, then eligible writer.
      disp_gnt = 1'b0;
      wr_gnt   = 1'b0;
      if (!rst) begin
         if (force_q && wr_ok) begin
            wr_gnt = 1'b1;
         end else if (disp_req) begin
            disp_gnt = 1'b1;
         end else if (wr_ok) begin
            wr_gnt = 1'b1;
         end
      end

      mem_en    = disp_gnt | wr_gnt;
      mem_we    = wr_gnt & wr_we;
      mem_addr  = '0;
      mem_wdata = '0;
      if (disp_gnt) begin
         mem_addr = disp_addr;
      end else if (wr_gnt) begin
         mem_addr  = wr_addr;
         mem_wdata = wr_wdata;
      end

      // Counter tracks consecutive cycles an eligible writer was refused.
      if (!wr_ok || wr_gnt) begin
         starve_cnt_d = '0;
      end else if (starve_cnt_q != STARVE_LIM) begin
         starve_cnt_d = starve_cnt_q + 8'd1;
      end else begin
         starve_cnt_d = starve_cnt_q;
      end
      // Force is raised one cycle after saturation and dropped by the grant
      // it causes, so a single forced slot is taken per starvation episode.
      force_d = wr_ok & ~wr_gnt & (starve_cnt_q == STARVE_LIM);

      if (disp_gnt) begin
         tag_d = TAG_DISP;
      end else if (wr_gnt && !wr_we) begin
         tag_d = TAG_WRD;
      end else begin
         tag_d = TAG_NONE;
      end

      // The RAM output register supplies data in the return cycle; the hold
      // registers keep the last returned word once rvalid drops.
      disp_rvalid = !rst && (tag_q == TAG_DISP);
      wr_rvalid   = !rst && (tag_q == TAG_WRD);
      disp_rdata  = rst ? '0 : (disp_rvalid ? mem_rdata : disp_rdata_q);
      wr_rdata    = rst ? '0 : (wr_rvalid ? mem_rdata : wr_rdata_q);
      disp_rdata_d = disp_rdata;
      wr_rdata_d   = wr_rdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt_q <= '0;
         force_q      <= 1'b0;
         tag_q        <= TAG_NONE;
         disp_rdata_q <= '0;
         wr_rdata_q   <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         force_q      <= force_d;
         tag_q        <= tag_d;
         disp_rdata_q <= disp_rdata_d;
         wr_rdata_q   <= wr_rdata_d;
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - self-checking bench for vram_arbiter
module tb_vram_arbiter;

   localparam int SMAX = 4;
   localparam int TF   = 1;

   logic       clk;
   logic       rst;
   logic       vblank;
   logic       disp_req;
   logic [3:0] disp_addr;
   logic       disp_gnt, disp_rvalid;
   logic [3:0] disp_rdata;
   logic       wr_req, wr_we;
   logic [3:0] wr_addr, wr_wdata;
   logic       wr_gnt, wr_rvalid;
   logic [3:0] wr_rdata;
   logic       mem_en, mem_we;
   logic [3:0] mem_addr, mem_wdata, mem_rdata;

   vram_arbiter #(.AW(4), .DW(4), .STARVE_MAX(SMAX), .TEAR_FREE(TF)) dut (
      .clk(clk), .rst(rst), .vblank(vblank),
      .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
      .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
      .wr_req(wr_req), .wr_we(wr_we), .wr_addr(wr_addr), .wr_wdata(wr_wdata),
      .wr_gnt(wr_gnt), .wr_rvalid(wr_rvalid), .wr_rdata(wr_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Write-first single-port synchronous board RAM.
   logic [3:0] ram [16];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            mem_rdata     <= mem_wdata;
         end else begin
            mem_rdata <= ram[mem_addr];
         end
      end
   end

   int n_cmp;
   int n_err;

   // Reference model state
   logic [3:0] shadow [16];
   int         m_streak;
   logic       m_pend_d, m_pend_w;
   logic [3:0] m_pend_d_data, m_pend_w_data, m_hold_d, m_hold_w;
   logic       m_dg, m_wg;

   typedef struct {
      logic       rst, vb, dr;
      logic [3:0] da;
      logic       wr, we;
      logic [3:0] wa, wd;
      logic       edg, ewg, een, ewe;
      logic [3:0] ea, ewd;
   } vec_t;

   vec_t tbl [8];

   function automatic vec_t mkv(input int r, input int vb, input int dr, input int da,
                                input int wr, input int we, input int wa, input int wd,
                                input int edg, input int ewg, input int een, input int ewe,
                                input int ea, input int ewd);
      vec_t v;
      v.rst = r[0];   v.vb = vb[0];   v.dr = dr[0];   v.da = 4'(da);
      v.wr = wr[0];   v.we = we[0];   v.wa = 4'(wa);  v.wd = 4'(wd);
      v.edg = edg[0]; v.ewg = ewg[0]; v.een = een[0]; v.ewe = ewe[0];
      v.ea = 4'(ea);  v.ewd = 4'(ewd);
      return v;
   endfunction

   function automatic logic [3:0] init_val(input int i);
      if (i == 5) return 4'd9;
      if (i == 3) return 4'd2;
      return 4'((i * 5 + 1) % 16);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // One clock cycle: check every output against the model, then advance.
   // Writer is forced once it has been refused more than SMAX cycles in a row.
   task automatic cycle();
      logic       elig, edg, ewg;
      logic [3:0] eaddr, ewd, erd_d, erd_w;
      logic       erv_d, erv_w;
      @(negedge clk);
      elig = wr_req && (vblank || TF == 0);
      edg = 1'b0;
      ewg = 1'b0;
      if (!rst) begin
         if (m_streak > SMAX && elig) ewg = 1'b1;
         else if (disp_req)           edg = 1'b1;
         else if (elig)               ewg = 1'b1;
      end
      eaddr = edg ? disp_addr : (ewg ? wr_addr : 4'd0);
      ewd   = ewg ? wr_wdata : 4'd0;
      erv_d = !rst && m_pend_d;
      erv_w = !rst && m_pend_w;
      erd_d = rst ? 4'd0 : (m_pend_d ? m_pend_d_data : m_hold_d);
      erd_w = rst ? 4'd0 : (m_pend_w ? m_pend_w_data : m_hold_w);
      chk("m_disp_gnt", disp_gnt, edg);
      chk("m_wr_gnt", wr_gnt, ewg);
      chk("m_mem_en", mem_en, edg | ewg);
      chk("m_mem_we", mem_we, ewg & wr_we);
      chk("m_mem_addr", mem_addr, eaddr);
      chk("m_mem_wdata", mem_wdata, ewd);
      chk("m_disp_rvalid", disp_rvalid, erv_d);
      chk("m_wr_rvalid", wr_rvalid, erv_w);
      chk("m_disp_rdata", disp_rdata, erd_d);
      chk("m_wr_rdata", wr_rdata, erd_w);
      if (rst) begin
         m_pend_d = 1'b0; m_pend_w = 1'b0;
         m_hold_d = 4'd0; m_hold_w = 4'd0;
         m_streak = 0;
      end else begin
         if (m_pend_d) m_hold_d = m_pend_d_data;
         if (m_pend_w) m_hold_w = m_pend_w_data;
         m_pend_d      = edg;
         m_pend_d_data = shadow[disp_addr];
         m_pend_w      = ewg && !wr_we;
         m_pend_w_data = shadow[wr_addr];
         if (ewg && wr_we) shadow[wr_addr] = wr_wdata;
         if (!elig || ewg) m_streak = 0;
         else m_streak++;
      end
      m_dg = edg;
      m_wg = ewg;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic wr_done;
      logic exp_w;
      n_cmp = 0; n_err = 0;
      rst = 1'b1; vblank = 1'b0; disp_req = 1'b0; disp_addr = 4'd0;
      wr_req = 1'b0; wr_we = 1'b0; wr_addr = 4'd0; wr_wdata = 4'd0;
      m_streak = 0; m_pend_d = 1'b0; m_pend_w = 1'b0;
      m_pend_d_data = 4'd0; m_pend_w_data = 4'd0; m_hold_d = 4'd0; m_hold_w = 4'd0;
      m_dg = 1'b0; m_wg = 1'b0;
      for (int i = 0; i < 16; i++) shadow[i] = 4'd0;

      tbl[0] = mkv(0,0,0, 2,0,0, 4, 1, 0,0,0,0, 0, 0);
      tbl[1] = mkv(0,0,1, 5,0,0, 3, 1, 1,0,1,0, 5, 0);
      tbl[2] = mkv(0,0,0, 5,1,1, 3, 7, 0,0,0,0, 0, 0);
      tbl[3] = mkv(0,1,0, 5,1,1, 3, 7, 0,1,1,1, 3, 7);
      tbl[4] = mkv(0,1,1, 9,1,1, 6, 2, 1,0,1,0, 9, 0);
      tbl[5] = mkv(0,1,0, 9,1,0,10,15, 0,1,1,0,10,15);
      tbl[6] = mkv(1,1,1, 9,1,1, 6, 2, 0,0,0,0, 0, 0);
      tbl[7] = mkv(0,0,1,12,1,1, 6, 2, 1,0,1,0,12, 0);

      repeat (2) @(posedge clk);
      #1;
      cycle();
      rst = 1'b0;

      // Idle after reset
      for (int i = 0; i < 10; i++) begin
         #1;
         chk("idle_gnt", disp_gnt | wr_gnt, 0);
         chk("idle_mem_en", mem_en, 0);
         chk("idle_rvalid", disp_rvalid | wr_rvalid, 0);
         cycle();
      end

      // Fill the board during vblank
      vblank = 1'b1;
      for (int i = 0; i < 16; i++) begin
         wr_req = 1'b1; wr_we = 1'b1; wr_addr = 4'(i); wr_wdata = init_val(i);
         #1;
         chk("fill_gnt", wr_gnt, 1);
         cycle();
      end
      wr_req = 1'b0;

      // Display read
      disp_req = 1'b1; disp_addr = 4'd5;
      #1;
      chk("rd_disp_gnt", disp_gnt, 1);
      cycle();
      disp_req = 1'b0;
      #1;
      chk("rd_disp_rvalid", disp_rvalid, 1);
      chk("rd_disp_rdata", disp_rdata, 9);
      cycle();

      // Writer blocked outside vblank
      vblank = 1'b0; wr_req = 1'b1; wr_we = 1'b1; wr_addr = 4'd3; wr_wdata = 4'd7;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("tf_wr_gnt", wr_gnt, 0);
         chk("tf_starve", dut.starve_cnt_q, 0);
         cycle();
      end
      vblank = 1'b1;
      #1;
      chk("tf_vblank_gnt", wr_gnt, 1);
      cycle();

      // Writer read then display read of the same cell
      wr_we = 1'b0;
      #1;
      chk("wrd_gnt", wr_gnt, 1);
      cycle();
      wr_req = 1'b0; disp_req = 1'b1; disp_addr = 4'd3;
      #1;
      chk("wrd_rvalid", wr_rvalid, 1);
      chk("wrd_rdata", wr_rdata, 7);
      chk("wrd_no_disp_rvalid", disp_rvalid, 0);
      chk("wrd_disp_gnt", disp_gnt, 1);
      cycle();
      disp_req = 1'b0;
      #1;
      chk("alt_disp_rvalid", disp_rvalid, 1);
      chk("alt_disp_rdata", disp_rdata, 7);
      chk("alt_no_wr_rvalid", wr_rvalid, 0);
      cycle();

      // Write followed by display read of the same address
      wr_req = 1'b1; wr_we = 1'b1; wr_addr = 4'd1; wr_wdata = 4'd13;
      #1;
      chk("wf_wr_gnt", wr_gnt, 1);
      cycle();
      wr_req = 1'b0; disp_req = 1'b1; disp_addr = 4'd1;
      #1;
      chk("wf_disp_gnt", disp_gnt, 1);
      cycle();
      disp_req = 1'b0;
      #1;
      chk("wf_disp_rdata", disp_rdata, 13);
      cycle();

      // Starvation: both requesting during vblank
      disp_req = 1'b1; disp_addr = 4'd7;
      wr_we = 1'b1; wr_addr = 4'd8; wr_wdata = 4'd11; wr_done = 1'b0;
      for (int c = 0; c < 8; c++) begin
         wr_req = !wr_done;
         #1;
         exp_w = (c == SMAX + 1);
         chk("starve_disp_gnt", disp_gnt, !exp_w);
         chk("starve_wr_gnt", wr_gnt, exp_w);
         chk("starve_exclusive", disp_gnt & wr_gnt, 0);
         if (exp_w) wr_done = 1'b1;
         cycle();
      end
      disp_req = 1'b0; wr_req = 1'b0;
      cycle();

      // Reset right after a display grant
      disp_req = 1'b1; disp_addr = 4'd5;
      wr_req = 1'b1; wr_we = 1'b1; wr_addr = 4'd14; wr_wdata = 4'd4;
      #1;
      chk("rst_pre_gnt", disp_gnt, 1);
      cycle();
      rst = 1'b1; disp_req = 1'b0;
      #1;
      chk("rst_rvalid_dropped", disp_rvalid, 0);
      chk("rst_no_mem_en", mem_en, 0);
      cycle();
      rst = 1'b0;
      #1;
      chk("rst_post_rvalid", disp_rvalid, 0);
      chk("rst_post_starve", dut.starve_cnt_q, 0);
      chk("rst_post_tag", 32'(dut.tag_q), 0);
      chk("rst_post_rdata", disp_rdata, 0);
      chk("rst_post_wr_gnt", wr_gnt, 1);
      cycle();
      wr_req = 1'b0; disp_req = 1'b1; disp_addr = 4'd5;
      cycle();
      disp_req = 1'b0;
      #1;
      chk("rst_resume_rdata", disp_rdata, 9);
      cycle();

      // Table of single-cycle vectors, each from a clean reset state
      for (int i = 0; i < 8; i++) begin
         rst = 1'b1; disp_req = 1'b0; wr_req = 1'b0;
         cycle();
         rst = tbl[i].rst; vblank = tbl[i].vb; disp_req = tbl[i].dr; disp_addr = tbl[i].da;
         wr_req = tbl[i].wr; wr_we = tbl[i].we; wr_addr = tbl[i].wa; wr_wdata = tbl[i].wd;
         #1;
         chk("tbl_disp_gnt", disp_gnt, tbl[i].edg);
         chk("tbl_wr_gnt", wr_gnt, tbl[i].ewg);
         chk("tbl_mem_en", mem_en, tbl[i].een);
         chk("tbl_mem_we", mem_we, tbl[i].ewe);
         chk("tbl_mem_addr", mem_addr, tbl[i].ea);
         chk("tbl_mem_wdata", mem_wdata, tbl[i].ewd);
         cycle();
      end
      rst = 1'b0; disp_req = 1'b0; wr_req = 1'b0;
      cycle();

      // Random traffic with protocol-legal holding of requests
      for (int n = 0; n < 2500; n++) begin
         if (!disp_req || m_dg) begin
            disp_req  = ($urandom_range(0, 9) < 8);
            disp_addr = 4'($urandom);
         end
         if (!wr_req || m_wg) begin
            wr_req   = ($urandom_range(0, 9) < 5);
            wr_we    = 1'($urandom);
            wr_addr  = 4'($urandom);
            wr_wdata = 4'($urandom);
         end
         if ($urandom_range(0, 19) == 0) vblank = !vblank;
         rst = ($urandom_range(0, 199) == 0);
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
